// File: rtl/booth_arith_pkg.sv
// Shared types and sizing constants for the Booth multiplier / divider datapath.
package booth_arith_pkg;

    localparam int N_SIZE_DEF = 8;
    localparam int D_SIZE_DEF = 4;
    localparam int CNT_W_DEF  = $clog2(N_SIZE_DEF);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } div_state_e;

    // Iteration counter width; kept at least one bit wide for degenerate sizes.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/signed_abs.sv
// Two's-complement magnitude with one extra bit so that -2^(W-1) stays representable.
module signed_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    output logic [W:0]   mag_o,
    output logic         sign_o
);

    logic [W:0] aExt;

    always_comb begin
        sign_o = a_i[W-1];
        aExt   = {a_i[W-1], a_i};
        mag_o  = sign_o ? (~aExt + 1'b1) : aExt;
    end

endmodule

// File: rtl/booth_seq_divider.sv
// Sequential signed radix-2 non-restoring divider with a start/done handshake;
// one quotient bit per cycle on operand magnitudes, signs applied in FIN.
module booth_seq_divider
    import booth_arith_pkg::*;
#(
    parameter int n_size = N_SIZE_DEF,
    parameter int d_size = D_SIZE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [n_size-1:0] N,
    input  logic [d_size-1:0] D,
    output logic              busy,
    output logic              done,
    output logic [n_size-1:0] Q,
    output logic [d_size-1:0] REM,
    output logic              div_zero,
    output logic              ovf
);

    localparam int CNT_W = cnt_width(n_size);
    localparam int RW    = d_size + 2;
    localparam logic [n_size:0]   NMIN_MAG = {2'b01, {(n_size-1){1'b0}}};
    localparam logic [n_size-1:0] QMIN     = {1'b1, {(n_size-1){1'b0}}};

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [n_size-1:0] quo_q, quo_d;
    logic [d_size:0]   dmag_q, dmag_d;
    logic              signN_q, signN_d;
    logic              signD_q, signD_d;
    logic              zero_q, zero_d;
    logic              ovfCond_q, ovfCond_d;

    logic [n_size-1:0] Q_q, Q_d;
    logic [d_size-1:0] REM_q, REM_d;
    logic              divZero_q, divZero_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic [n_size:0]   nMag;
    logic              nSign;
    logic [d_size:0]   dMag;
    logic              dSign;

    logic [RW-1:0]     remShift;
    logic [RW-1:0]     remStep;
    logic [d_size-1:0] remMag;

    signed_abs #(.W(n_size)) uAbsN (
        .a_i    (N),
        .mag_o  (nMag),
        .sign_o (nSign)
    );

    signed_abs #(.W(d_size)) uAbsD (
        .a_i    (D),
        .mag_o  (dMag),
        .sign_o (dSign)
    );

    // Non-restoring step: subtract while the partial remainder is non-negative, else add back.
    always_comb begin
        remShift = {rem_q[RW-2:0], quo_q[n_size-1]};
        remStep  = rem_q[RW-1] ? (remShift + {1'b0, dmag_q})
                               : (remShift - {1'b0, dmag_q});
        remMag   = rem_q[RW-1] ? (rem_q[d_size-1:0] + dmag_q[d_size-1:0])
                               : rem_q[d_size-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dmag_d    = dmag_q;
        signN_d   = signN_q;
        signD_d   = signD_q;
        zero_d    = zero_q;
        ovfCond_d = ovfCond_q;
        Q_d       = Q_q;
        REM_d     = REM_q;
        divZero_d = divZero_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    quo_d     = nMag[n_size-1:0];
                    dmag_d    = dMag;
                    signN_d   = nSign;
                    signD_d   = dSign;
                    zero_d    = (dMag == '0);
                    ovfCond_d = nSign && (nMag == NMIN_MAG) && dSign && (dMag == {{d_size{1'b0}}, 1'b1});
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = CALC;
                end
            end
            CALC: begin
                rem_d = remStep;
                quo_d = {quo_q[n_size-2:0], ~remStep[RW-1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(n_size - 1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (zero_q) begin
                    Q_d   = '0;
                    REM_d = '0;
                end else if (ovfCond_q) begin
                    Q_d   = QMIN;
                    REM_d = '0;
                end else begin
                    Q_d   = (signN_q ^ signD_q) ? (~quo_q + 1'b1) : quo_q;
                    REM_d = signN_q ? (~remMag + 1'b1) : remMag;
                end
                divZero_d = zero_q;
                ovf_d     = ovfCond_q && !zero_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset clears everything, so an aborted divide leaves no trace and no done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dmag_q    <= '0;
            signN_q   <= 1'b0;
            signD_q   <= 1'b0;
            zero_q    <= 1'b0;
            ovfCond_q <= 1'b0;
            Q_q       <= '0;
            REM_q     <= '0;
            divZero_q <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dmag_q    <= dmag_d;
            signN_q   <= signN_d;
            signD_q   <= signD_d;
            zero_q    <= zero_d;
            ovfCond_q <= ovfCond_d;
            Q_q       <= Q_d;
            REM_q     <= REM_d;
            divZero_q <= divZero_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign Q        = Q_q;
    assign REM      = REM_q;
    assign div_zero = divZero_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed bench for booth_seq_divider: reset, sign quadrants, extremes, divide by zero,
// back-to-back handshake, input changes mid-divide and reset mid-divide.
module tb_booth_seq_divider;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] N;
    logic [3:0] D;
    logic       busy;
    logic       done;
    logic [7:0] Q;
    logic [3:0] REM;
    logic       div_zero;
    logic       ovf;

    int errors;
    int checks;

    booth_seq_divider #(.n_size(8), .d_size(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .N        (N),
        .D        (D),
        .busy     (busy),
        .done     (done),
        .Q        (Q),
        .REM      (REM),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents operands with start for exactly one rising edge (edge 0), returning #1 after it.
    task automatic applyStimulus(input logic [7:0] n, input logic [3:0] d);
        @(negedge clk);
        N     = n;
        D     = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic runDivide(input string tag, input logic [7:0] n, input logic [3:0] d,
                             input logic [7:0] eQ, input logic [3:0] eR,
                             input logic eZ, input logic eO, input int mutateAt);
        int cycles;
        int busyCnt;
        applyStimulus(n, d);
        cycles  = 0;
        busyCnt = busy ? 1 : 0;
        while (done !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy) busyCnt++;
            if (cycles == mutateAt) begin
                N = ~n;
                D = d + 4'd3;
            end
        end
        $display("[TB] %s: done after %0d cycles", tag, cycles);
        checkOutput({tag, ".latency"}, cycles, 9);
        checkOutput({tag, ".busyCycles"}, busyCnt, 9);
        checkOutput({tag, ".Q"}, Q, eQ);
        checkOutput({tag, ".REM"}, REM, eR);
        checkOutput({tag, ".divZero"}, div_zero, eZ);
        checkOutput({tag, ".ovf"}, ovf, eO);
        @(posedge clk);
        #1;
        checkOutput({tag, ".donePulse"}, done, 1'b0);
    endtask

    initial begin
        int doneCnt;
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        N      = '0;
        D      = '0;

        // Reset and idle behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset.busy", busy, 1'b0);
            checkOutput("reset.done", done, 1'b0);
            checkOutput("reset.Q", Q, 8'h00);
            checkOutput("reset.REM", REM, 4'h0);
        end

        // Sign quadrants
        runDivide("p7_p2", 8'd7,  4'd2,  8'h03, 4'h1, 1'b0, 1'b0, 0);
        runDivide("n7_p2", 8'hF9, 4'd2,  8'hFD, 4'hF, 1'b0, 1'b0, 0);
        runDivide("p7_n2", 8'd7,  4'hE,  8'hFD, 4'h1, 1'b0, 1'b0, 0);
        runDivide("n7_n2", 8'hF9, 4'hE,  8'h03, 4'hF, 1'b0, 1'b0, 0);

        // Extremes
        runDivide("p127_n8",  8'd127, 4'h8, 8'hF1, 4'h7, 1'b0, 1'b0, 0);
        runDivide("n128_n1",  8'h80,  4'hF, 8'h80, 4'h0, 1'b0, 1'b1, 0);
        runDivide("n128_p1",  8'h80,  4'h1, 8'h80, 4'h0, 1'b0, 1'b0, 0);

        // Divide by zero, then a normal divide clears the flag
        runDivide("p100_z", 8'd100, 4'h0, 8'h00, 4'h0, 1'b1, 1'b0, 0);
        runDivide("p6_p3",  8'd6,   4'd3, 8'h02, 4'h0, 1'b0, 1'b0, 0);

        // start held for 20 edges: second request accepted in the done cycle
        @(negedge clk);
        N       = 8'd9;
        D       = 4'd4;
        start   = 1'b1;
        doneCnt = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (done) begin
                doneCnt++;
                checkOutput("hold.Q", Q, 8'h02);
                checkOutput("hold.REM", REM, 4'h1);
                if (doneCnt == 1) checkOutput("hold.firstDoneEdge", e, 9);
                else              checkOutput("hold.secondDoneEdge", e, 19);
            end
        end
        start = 1'b0;
        checkOutput("hold.doneCount", doneCnt, 2);
        checkOutput("hold.busyAfter", busy, 1'b0);
        @(posedge clk);
        #1;

        // Operand changes while busy are ignored
        runDivide("mutate_p9_p4", 8'd9, 4'd4, 8'h02, 4'h1, 1'b0, 1'b0, 3);

        // Reset mid-divide aborts with no done pulse
        applyStimulus(8'd50, 4'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.busy", busy, 1'b0);
        checkOutput("abort.Q", Q, 8'h00);
        checkOutput("abort.REM", REM, 4'h0);
        doneCnt = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) doneCnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done) doneCnt++;
        end
        checkOutput("abort.noDone", doneCnt, 0);
        runDivide("p50_p7", 8'd50, 4'd7, 8'h07, 4'h1, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
